// File: rtl/vlsu_obi_adapter.sv
// OBI data-bus adapter for the vector LSU: registered request slot,
// in-order response FIFO and credit-based LSU backpressure.
module vlsu_obi_adapter #(
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        lsu_req_i,
  output logic        lsu_gnt_o,
  input  logic [31:0] lsu_addr_i,
  input  logic        lsu_we_i,
  input  logic [3:0]  lsu_be_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_rvalid_o,
  input  logic        lsu_rready_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic        busy_o,
  output logic        proto_err_o
);

  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
  localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned UW = CW + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t        r_state;
  logic          r_req_valid;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_we;
  logic [3:0]    r_be;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW-1:0] r_twp;
  logic [PW-1:0] r_trp;
  logic [32:0]   r_mem [RESP_DEPTH];
  logic          r_tag [RESP_DEPTH];
  logic          r_proto;

  logic          w_grant;
  logic          w_rvalid;
  logic          w_pop;
  logic          w_full;
  logic          w_acc;
  logic          w_push;
  logic          w_gnt;
  logic          w_xfer;
  logic [UW-1:0] w_used;
  logic [UW-1:0] w_used_nxt;
  logic          w_req_nxt;
  logic [CW-1:0] w_outst_nxt;
  logic [CW-1:0] w_cnt_nxt;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_used   = UW'(r_req_valid) + UW'(r_outst) + UW'(r_cnt);
  assign w_grant  = r_req_valid & data_gnt_i;
  assign w_rvalid = r_cnt != '0;
  assign w_pop    = w_rvalid & lsu_rready_i;
  assign w_full   = r_cnt == CW'(RESP_DEPTH);
  assign w_acc    = data_rvalid_i & (r_outst != '0);
  assign w_push   = w_acc & (!w_full | w_pop);

  // A pending ungranted request must not be overwritten by a new transfer.
  assign w_gnt = n_reset & (!r_req_valid | data_gnt_i) &
                 ((w_used < UW'(RESP_DEPTH)) |
                  (w_grant & (w_used == UW'(RESP_DEPTH)) & w_pop));
  assign w_xfer = lsu_req_i & w_gnt;

  assign w_req_nxt   = w_xfer | (r_req_valid & !data_gnt_i);
  assign w_outst_nxt = r_outst + CW'(w_grant) - CW'(w_acc);
  assign w_cnt_nxt   = r_cnt + CW'(w_push) - CW'(w_pop);
  assign w_used_nxt  = UW'(w_req_nxt) + UW'(w_outst_nxt) + UW'(w_cnt_nxt);

  assign lsu_gnt_o    = w_gnt;
  assign lsu_rvalid_o = w_rvalid;
  assign lsu_rdata_o  = w_rvalid ? r_mem[r_rp][32:1] : '0;
  assign lsu_err_o    = w_rvalid & r_mem[r_rp][0];
  assign data_req_o   = r_req_valid;
  assign data_addr_o  = r_addr;
  assign data_we_o    = r_we;
  assign data_be_o    = r_be;
  assign data_wdata_o = r_wdata;
  assign busy_o       = r_state != IDLE;
  assign proto_err_o  = r_proto;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_req_valid <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_be        <= '0;
    end else if (w_xfer) begin
      r_req_valid <= 1'b1;
      r_addr      <= lsu_addr_i;
      r_wdata     <= lsu_wdata_i;
      r_we        <= lsu_we_i;
      r_be        <= lsu_be_i;
    end else if (w_grant) begin
      r_req_valid <= 1'b0;
    end
  end

  // Tag queue advances with grants and accepted responses, FIFO with push/pop.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_outst <= '0;
      r_cnt   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_twp   <= '0;
      r_trp   <= '0;
      r_proto <= 1'b0;
      for (int i = 0; i < int'(RESP_DEPTH); i++) begin
        r_mem[i] <= '0;
        r_tag[i] <= 1'b0;
      end
    end else begin
      r_outst <= w_outst_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_grant) begin
        r_tag[r_twp] <= r_we;
        r_twp        <= f_inc(r_twp);
      end
      if (w_acc) r_trp <= f_inc(r_trp);
      if (w_push) begin
        r_mem[r_wp] <= {r_tag[r_trp] ? 32'h0 : data_rdata_i, data_err_i};
        r_wp        <= f_inc(r_wp);
      end
      if (w_pop) r_rp <= f_inc(r_rp);
      if (data_rvalid_i && r_outst == '0) r_proto <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE:  if (w_xfer) r_state <= ISSUE;
        ISSUE: if (w_grant && !w_xfer) r_state <= DRAIN;
        DRAIN: begin
          if (w_xfer)                r_state <= ISSUE;
          else if (w_used_nxt == '0) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  a_no_ovf: assert property (@(posedge clk) disable iff (!n_reset)
    !(w_acc && w_full && !w_pop));

endmodule

// File: tb/tb_vlsu_obi_adapter.sv
// Directed bench for vlsu_obi_adapter with hand-computed expectations.
// Inputs change 1 time unit after posedge; outputs sampled 1 unit later.
module tb_vlsu_obi_adapter;

  logic        clk;
  logic        n_reset;
  logic        lsu_req_i;
  logic        lsu_gnt_o;
  logic [31:0] lsu_addr_i;
  logic        lsu_we_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_rvalid_o;
  logic        lsu_rready_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_err_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        data_err_i;
  logic        busy_o;
  logic        proto_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  vlsu_obi_adapter #(.RESP_DEPTH(2)) dut (
    .clk(clk), .n_reset(n_reset),
    .lsu_req_i(lsu_req_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_addr_i(lsu_addr_i), .lsu_we_i(lsu_we_i),
    .lsu_be_i(lsu_be_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rready_i(lsu_rready_i),
    .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .data_err_i(data_err_i), .busy_o(busy_o),
    .proto_err_o(proto_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lsu_drive(input logic req, input logic [31:0] addr,
                           input logic we, input logic [3:0] be,
                           input logic [31:0] wd);
    lsu_req_i   = req;
    lsu_addr_i  = addr;
    lsu_we_i    = we;
    lsu_be_i    = be;
    lsu_wdata_i = wd;
  endtask

  task automatic bus_resp(input logic v, input logic [31:0] rd,
                          input logic e);
    data_rvalid_i = v;
    data_rdata_i  = rd;
    data_err_i    = e;
  endtask

  initial begin
    n_reset = 1'b0;
    lsu_drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    lsu_rready_i = 1'b0;
    data_gnt_i   = 1'b0;
    bus_resp(1'b0, 32'h0, 1'b0);

    // reset state
    step();
    #1;
    check("rst_gnt", 32'(lsu_gnt_o), 32'd0);
    check("rst_req", 32'(data_req_o), 32'd0);
    check("rst_rvalid", 32'(lsu_rvalid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_proto", 32'(proto_err_o), 32'd0);
    check("rst_addr", data_addr_o, 32'h0);
    step();
    n_reset = 1'b1;

    // 1: single load
    step();
    lsu_drive(1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
    #1;
    check("t1_gnt", 32'(lsu_gnt_o), 32'd1);
    check("t1_req_n", 32'(data_req_o), 32'd0);
    step();
    lsu_drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    data_gnt_i = 1'b1;
    #1;
    check("t1_req_n1", 32'(data_req_o), 32'd1);
    check("t1_addr", data_addr_o, 32'h100);
    check("t1_we", 32'(data_we_o), 32'd0);
    check("t1_busy", 32'(busy_o), 32'd1);
    step();
    data_gnt_i = 1'b0;
    #1;
    check("t1_req_off", 32'(data_req_o), 32'd0);
    step();
    bus_resp(1'b1, 32'hDEADBEEF, 1'b0);
    #1;
    check("t1_rv_early", 32'(lsu_rvalid_o), 32'd0);
    step();
    bus_resp(1'b0, 32'h0, 1'b0);
    lsu_rready_i = 1'b1;
    #1;
    check("t1_rvalid", 32'(lsu_rvalid_o), 32'd1);
    check("t1_rdata", lsu_rdata_o, 32'hDEADBEEF);
    check("t1_err", 32'(lsu_err_o), 32'd0);
    step();
    lsu_rready_i = 1'b0;
    #1;
    check("t1_rv_done", 32'(lsu_rvalid_o), 32'd0);
    check("t1_idle", 32'(busy_o), 32'd0);

    // 2/4: load, back-to-back store stalled 5 cycles, responses with error
    step();
    lsu_drive(1'b1, 32'h200, 1'b0, 4'hF, 32'h0);
    #1;
    check("t2_gnt_a", 32'(lsu_gnt_o), 32'd1);
    step();
    data_gnt_i = 1'b1;
    lsu_drive(1'b1, 32'h300, 1'b1, 4'b0011, 32'h1234);
    #1;
    check("t2_gnt_b2b", 32'(lsu_gnt_o), 32'd1);
    step();
    data_gnt_i = 1'b0;
    lsu_drive(1'b1, 32'h500, 1'b0, 4'hF, 32'hFFFF);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t2_hold_req", 32'(data_req_o), 32'd1);
      check("t2_hold_addr", data_addr_o, 32'h300);
      check("t2_hold_be", 32'(data_be_o), 32'h3);
      check("t2_hold_wd", data_wdata_o, 32'h1234);
      check("t2_hold_we", 32'(data_we_o), 32'd1);
      check("t2_no_gnt", 32'(lsu_gnt_o), 32'd0);
      step();
    end
    lsu_drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    data_gnt_i = 1'b1;
    #1;
    check("t2_req_g", 32'(data_req_o), 32'd1);
    step();
    data_gnt_i = 1'b0;
    bus_resp(1'b1, 32'h11111111, 1'b0);
    lsu_rready_i = 1'b1;
    #1;
    check("t2_rv_empty", 32'(lsu_rvalid_o), 32'd0);
    check("t2_req_off", 32'(data_req_o), 32'd0);
    step();
    bus_resp(1'b1, 32'h99999999, 1'b1);
    #1;
    check("t4_ld_rv", 32'(lsu_rvalid_o), 32'd1);
    check("t4_ld_data", lsu_rdata_o, 32'h11111111);
    check("t4_ld_err", 32'(lsu_err_o), 32'd0);
    step();
    bus_resp(1'b0, 32'h0, 1'b0);
    #1;
    check("t4_st_rv", 32'(lsu_rvalid_o), 32'd1);
    check("t4_st_data", lsu_rdata_o, 32'h0);
    check("t4_st_err", 32'(lsu_err_o), 32'd1);
    step();
    lsu_rready_i = 1'b0;
    #1;
    check("t2_rv_done", 32'(lsu_rvalid_o), 32'd0);
    check("t2_idle", 32'(busy_o), 32'd0);

    // 3: credit exhaustion with rready low, in-order drain
    step();
    lsu_drive(1'b1, 32'hA0, 1'b0, 4'hF, 32'h0);
    #1;
    check("t3_gnt_a", 32'(lsu_gnt_o), 32'd1);
    step();
    data_gnt_i = 1'b1;
    lsu_drive(1'b1, 32'hB0, 1'b0, 4'hF, 32'h0);
    #1;
    check("t3_gnt_b", 32'(lsu_gnt_o), 32'd1);
    step();
    lsu_drive(1'b1, 32'hC0, 1'b0, 4'hF, 32'h0);
    #1;
    check("t3_addr_b", data_addr_o, 32'hB0);
    check("t3_gnt_c0", 32'(lsu_gnt_o), 32'd0);
    step();
    data_gnt_i = 1'b0;
    bus_resp(1'b1, 32'hA, 1'b0);
    #1;
    check("t3_gnt_c1", 32'(lsu_gnt_o), 32'd0);
    check("t3_rv_empty", 32'(lsu_rvalid_o), 32'd0);
    step();
    bus_resp(1'b1, 32'hB, 1'b0);
    #1;
    check("t3_head_a0", lsu_rdata_o, 32'hA);
    check("t3_gnt_c2", 32'(lsu_gnt_o), 32'd0);
    step();
    bus_resp(1'b0, 32'h0, 1'b0);
    lsu_rready_i = 1'b1;
    #1;
    check("t3_pop_a", lsu_rdata_o, 32'hA);
    check("t3_gnt_c3", 32'(lsu_gnt_o), 32'd0);
    step();
    lsu_rready_i = 1'b0;
    #1;
    check("t3_head_b", lsu_rdata_o, 32'hB);
    check("t3_gnt_c", 32'(lsu_gnt_o), 32'd1);
    step();
    lsu_drive(1'b1, 32'hD0, 1'b0, 4'hF, 32'h0);
    data_gnt_i   = 1'b1;
    lsu_rready_i = 1'b1;
    #1;
    check("t3_addr_c", data_addr_o, 32'hC0);
    check("t3_pop_b", lsu_rdata_o, 32'hB);
    check("t3_gnt_full", 32'(lsu_gnt_o), 32'd1);
    step();
    lsu_drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    lsu_rready_i = 1'b0;
    #1;
    check("t3_addr_d", data_addr_o, 32'hD0);
    check("t3_rv_b_gone", 32'(lsu_rvalid_o), 32'd0);
    step();
    data_gnt_i = 1'b0;
    bus_resp(1'b1, 32'hC, 1'b0);
    step();
    bus_resp(1'b1, 32'hD, 1'b0);
    lsu_rready_i = 1'b1;
    #1;
    check("t3_head_c", lsu_rdata_o, 32'hC);
    step();
    bus_resp(1'b0, 32'h0, 1'b0);
    #1;
    check("t3_head_d", lsu_rdata_o, 32'hD);
    step();
    lsu_rready_i = 1'b0;
    #1;
    check("t3_rv_done", 32'(lsu_rvalid_o), 32'd0);
    check("t3_idle", 32'(busy_o), 32'd0);

    // 5: stray response
    step();
    bus_resp(1'b1, 32'h77, 1'b0);
    step();
    bus_resp(1'b0, 32'h0, 1'b0);
    #1;
    check("t5_no_rv", 32'(lsu_rvalid_o), 32'd0);
    check("t5_proto", 32'(proto_err_o), 32'd1);
    step();
    step();
    #1;
    check("t5_sticky", 32'(proto_err_o), 32'd1);
    n_reset = 1'b0;
    #1;
    check("t5_rst_clr", 32'(proto_err_o), 32'd0);
    step();
    n_reset = 1'b1;

    // 6: reset mid-transaction
    step();
    lsu_drive(1'b1, 32'h400, 1'b0, 4'hF, 32'h0);
    step();
    data_gnt_i = 1'b1;
    lsu_drive(1'b1, 32'h404, 1'b0, 4'hF, 32'h0);
    step();
    data_gnt_i = 1'b0;
    lsu_drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    #1;
    check("t6_pre_req", 32'(data_req_o), 32'd1);
    n_reset = 1'b0;
    #1;
    check("t6_req", 32'(data_req_o), 32'd0);
    check("t6_addr", data_addr_o, 32'h0);
    check("t6_busy", 32'(busy_o), 32'd0);
    check("t6_gnt", 32'(lsu_gnt_o), 32'd0);
    check("t6_rv", 32'(lsu_rvalid_o), 32'd0);
    step();
    n_reset = 1'b1;
    step();
    #1;
    check("t6_req_after", 32'(data_req_o), 32'd0);
    bus_resp(1'b1, 32'h404, 1'b0);
    step();
    bus_resp(1'b0, 32'h0, 1'b0);
    #1;
    check("t6_late_proto", 32'(proto_err_o), 32'd1);
    check("t6_late_rv", 32'(lsu_rvalid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
